// File: rtl/param_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : param_decoder_scan
// Description : Registered N-to-2^N decoder with polarity select, enable and
//               an autonomous one-hot/one-cold scan mode with programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module param_decoder_scan #(
    parameter int IN_W       = 3,
    parameter int ACTIVE_LOW = 0,
    parameter int HOLD_CYC   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [IN_W-1:0]         sel,
    output logic [(1 << IN_W)-1:0]  dec_out,
    output logic [IN_W-1:0]         cur_idx,
    output logic                    wrap,
    output logic                    busy
);

    localparam int OUT_W = 1 << IN_W;
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic             c_AL         = (ACTIVE_LOW != 0);
    localparam logic [OUT_W-1:0] c_INACT      = {OUT_W{c_AL}};
    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DIRECT = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_dwell;
    logic [IN_W-1:0]  r_cur_idx;
    logic [OUT_W-1:0] r_dec;
    logic             r_wrap;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_dwell_nxt;
    logic [IN_W-1:0]  w_idx_nxt;
    logic [OUT_W-1:0] w_dec_nxt;
    logic             w_wrap_nxt;
    logic             w_busy_nxt;
    logic [IN_W-1:0]  w_idx_inc;
    logic             w_dwell_done;

    function automatic logic [OUT_W-1:0] f_active(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = c_INACT;
        v[idx] = ~c_AL;
        return v;
    endfunction

    assign w_idx_inc    = r_cur_idx + 1'b1;
    assign w_dwell_done = (r_dwell == c_DWELL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_dwell   <= '0;
            r_cur_idx <= '0;
            r_dec     <= c_INACT;
            r_wrap    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dwell   <= w_dwell_nxt;
            r_cur_idx <= w_idx_nxt;
            r_dec     <= w_dec_nxt;
            r_wrap    <= w_wrap_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = c_ST_IDLE;
        end else if (mode) begin
            w_state_nxt = c_ST_SCAN;
        end else begin
            w_state_nxt = c_ST_DIRECT;
        end
    end

    // Values computed here are what the registers present one cycle later.
    always_comb begin
        w_dwell_nxt = '0;
        w_idx_nxt   = r_cur_idx;
        w_dec_nxt   = r_dec;
        w_wrap_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        case (w_state_nxt)
            c_ST_IDLE: begin
                w_dec_nxt = c_INACT;
            end
            c_ST_DIRECT: begin
                if (sel_valid) begin
                    w_idx_nxt = sel;
                    w_dec_nxt = f_active(sel);
                end
            end
            c_ST_SCAN: begin
                w_busy_nxt = 1'b1;
                if (r_state != c_ST_SCAN) begin
                    w_idx_nxt = '0;
                    w_dec_nxt = f_active('0);
                end else if (w_dwell_done) begin
                    w_idx_nxt  = w_idx_inc;
                    w_dec_nxt  = f_active(w_idx_inc);
                    w_wrap_nxt = (r_cur_idx == {IN_W{1'b1}});
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            default: begin
                w_dec_nxt = c_INACT;
            end
        endcase
    end

    assign dec_out = r_dec;
    assign cur_idx = r_cur_idx;
    assign wrap    = r_wrap;
    assign busy    = r_busy;

endmodule
`default_nettype wire
